fft_bitrev_reorder: RTL
=======================

# fft_bitrev_reorder

Output reorder buffer placed directly downstream of the radix-2^2 SDF FFT pipeline. It takes the bit-reversed-order complex sample stream the last butterfly stage produces and returns each N-point frame in natural frequency order. It uses a ping-pong pair of N-entry banks, so input can stream continuously at one sample per enabled cycle while the previous frame is read out.

## Interface
- DATA_WIDTH, 16, width of each real/imag component (two's complement, passed through unmodified)
- N_POINTS, 16, frame length; power of 2, >= 4
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global enable; when 0 every register holds, including RAM writes and reads
- in_val  in  1  input sample valid (qualified by en)
- in_sof  in  1  first sample of a frame; sampled only when in_val=1
- in_re, in_im  in  DATA_WIDTH  input sample, bit-reversed frame order
- out_val  out  1  output sample valid
- out_sof  out  1  high with out_val on natural index 0
- out_re, out_im  out  DATA_WIDTH  output sample, natural order
- sof_err  out  1  one-cycle pulse when in_sof arrives mid-frame

## Operation
- LOG2N = clog2(N_POINTS). An accepted sample is a cycle with en=1 and in_val=1.
- Write side: wr_cnt (LOG2N bits), wr_bank (1 bit), bank_full[1:0].
  - An accepted sample is written to bank wr_bank at address bitrev(wr_cnt), then wr_cnt increments.
  - An accepted sample with in_sof=1 is treated as wr_cnt=0, i.e. written to address 0. If the old wr_cnt was not 0, sof_err pulses on the next cycle and the partial frame is discarded. The bank stays the same and is not marked full.
  - Before the first in_sof after reset, input is accepted from wr_cnt=0 as if in_sof had been given.
  - The write of wr_cnt=N-1 sets bank_full[wr_bank], toggles wr_bank and wraps wr_cnt to 0.
- Read side FSM, states IDLE and READ.
  - IDLE -> READ when bank_full[rd_bank]=1. rd_cnt is set to 0 on that transition.
  - In READ, the block reads address rd_cnt from bank rd_bank and increments rd_cnt every enabled cycle.
  - When rd_cnt=N-1 is issued: clear bank_full[rd_bank] and toggle rd_bank. Stay in READ (rd_cnt wraps to 0) if the other bank is full, including if it becomes full on that same edge. Otherwise go to IDLE.
- The RAM read is registered. out_val/out_sof/out_re/out_im are the registered read data and its flags; out_sof = (the issued rd_cnt was 0).
- No backpressure exists. Read rate equals the maximum write rate, so a write into a bank still being drained never overwrites an unread address (frame k+2 sample j is written no earlier than the read of bitrev(j) in frame k). This is a bench assertion: a write at wr_cnt=0 into a full bank is legal only if that bank clears on the same edge.
- A simultaneous set (writer) and clear (reader) of the same bank_full bit cannot occur; the bench asserts it.

## Timing
- Reset values:
  - outputs: out_val=0, out_sof=0, out_re=0, out_im=0, sof_err=0
  - internal: wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, bank_full=0, FSM=IDLE
  - RAM contents are not reset.
- Reset mid-operation discards both banks and any partial frame; output stops on the next cycle.
- Latency, counted in enabled cycles (cycles with en=0 stretch every figure):
  - Last sample of a frame accepted at edge E0. bank_full is set at E0.
  - FSM enters READ at E1.
  - out_val=1 with out_sof=1 holds after E2.
  - The frame occupies N consecutive enabled cycles.
- With continuous input, frames come out back-to-back with no gap cycles.
- sof_err is asserted in the cycle after the offending edge, for one cycle.

## Structure
- Package fft_pkg holds the bitrev(idx, LOG2N) function and a complex-sample struct {re, im} of DATA_WIDTH each; upstream stages reuse both.
- One sub-module, fft_pingpong_ram:
  - simple dual-port memory, 2*N_POINTS x 2*DATA_WIDTH
  - address is {bank, index}
  - one write port, one registered read port, both gated by en
- Counters, bank_full and the FSM live in fft_bitrev_reorder.

## Test plan
- N=16, one frame: input value i at bit-reversed position bitrev(i) (in_re=in_im=i), in_sof on the first -> out_re=0..15 in order, out_sof only on 0, first out_val 2 cycles after the last input.
- Three frames back-to-back with no idle cycles (values 0..47 encoded per frame) -> 48 consecutive out_val cycles in natural order per frame, no gaps, no corruption; no-overwrite assertion holds.
- Random in_val gaps (50%) and random en=0 cycles -> same output sequence as the previous test; outputs hold during en=0.
- in_sof asserted at wr_cnt=5 -> sof_err pulse one cycle later; partial frame dropped; the next 16 samples are emitted correctly as one frame.
- rst low while frame 1 is being read and frame 2 is half written -> out_val=0 next cycle, no output from stale data; a new frame after reset comes out correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: complex sample struct and index bit reversal.
package fft_pkg;

  localparam int CPLX_DW = 16;

  typedef struct packed {
    logic signed [CPLX_DW-1:0] re;
    logic signed [CPLX_DW-1:0] im;
  } cplx_t;

  // Reverses the low log2n bits of idx; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int log2n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < log2n) r[i] = idx[log2n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream into and out of the bit-reversal reorder buffer.
interface fft_bitrev_reorder_if #(
  parameter int DATA_WIDTH = 16
);
  import fft_pkg::*;

  logic                  in_val;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_re;
  logic [DATA_WIDTH-1:0] in_im;
  logic                  out_val;
  logic                  out_sof;
  logic [DATA_WIDTH-1:0] out_re;
  logic [DATA_WIDTH-1:0] out_im;
  logic                  sof_err;

  modport master (
    output in_val, in_sof, in_re, in_im,
    input  out_val, out_sof, out_re, out_im, sof_err
  );

  modport slave (
    input  in_val, in_sof, in_re, in_im,
    output out_val, out_sof, out_re, out_im, sof_err
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample memory: one write port, one registered read port, both gated by en.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16,
  localparam int AW        = $clog2(2 * N_POINTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    i_wr_en,
  input  logic [AW-1:0]           i_wr_addr,
  input  logic [2*DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_rd_en,
  input  logic [AW-1:0]           i_rd_addr,
  output logic [2*DATA_WIDTH-1:0] o_rd_data
);

  logic [2*DATA_WIDTH-1:0] r_mem [0:2*N_POINTS-1];
  logic [2*DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (en && i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Only the read register is reset so the block outputs start at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (en && i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output frames in, natural-order frames out.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 en,
  fft_bitrev_reorder_if.slave bus
);

  localparam int LOG2N = $clog2(N_POINTS);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);

  typedef enum logic {S_IDLE, S_READ} rd_state_t;

  rd_state_t               r_state;
  logic [LOG2N-1:0]        r_wr_cnt;
  logic [LOG2N-1:0]        r_rd_cnt;
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic [1:0]              r_bank_full;
  logic                    r_out_val;
  logic                    r_out_sof;
  logic                    r_sof_err;

  logic                    w_acc;
  logic [LOG2N-1:0]        w_wr_idx;
  logic [LOG2N-1:0]        w_wr_addr;
  logic                    w_wr_last;
  logic                    w_rd_issue;
  logic                    w_rd_last;
  logic                    w_other_full;
  logic [1:0]              w_full_nxt;
  logic [2*DATA_WIDTH-1:0] w_rd_data;

  assign w_acc        = en && bus.in_val;
  assign w_wr_idx     = bus.in_sof ? '0 : r_wr_cnt;
  assign w_wr_addr    = LOG2N'(bitrev(32'(w_wr_idx), LOG2N));
  assign w_wr_last    = w_acc && (w_wr_idx == LAST);
  assign w_rd_issue   = en && (r_state == S_READ);
  assign w_rd_last    = w_rd_issue && (r_rd_cnt == LAST);
  // The other bank counts as ready if the writer completes it on this same edge.
  assign w_other_full = r_bank_full[~r_rd_bank] || (w_wr_last && (r_wr_bank != r_rd_bank));

  always_comb begin
    w_full_nxt = r_bank_full;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_out_val   <= 1'b0;
      r_out_sof   <= 1'b0;
      r_sof_err   <= 1'b0;
    end else if (en) begin
      r_sof_err   <= bus.in_val && bus.in_sof && (r_wr_cnt != '0);
      r_bank_full <= w_full_nxt;
      r_out_val   <= (r_state == S_READ);
      r_out_sof   <= (r_state == S_READ) && (r_rd_cnt == '0);
      if (bus.in_val) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= w_wr_idx + LOG2N'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (r_bank_full[r_rd_bank]) begin
            r_state  <= S_READ;
            r_rd_cnt <= '0;
          end
        end
        S_READ: begin
          r_rd_cnt <= r_rd_cnt + LOG2N'(1);
          if (w_rd_last) begin
            r_rd_bank <= ~r_rd_bank;
            if (!w_other_full) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fft_pingpong_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_POINTS   (N_POINTS)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i_wr_en   (bus.in_val),
    .i_wr_addr ({r_wr_bank, w_wr_addr}),
    .i_wr_data ({bus.in_re, bus.in_im}),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr ({r_rd_bank, r_rd_cnt}),
    .o_rd_data (w_rd_data)
  );

  assign bus.out_val = r_out_val;
  assign bus.out_sof = r_out_sof;
  assign bus.out_re  = w_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign bus.out_im  = w_rd_data[DATA_WIDTH-1:0];
  assign bus.sof_err = r_sof_err;

endmodule
